// File: rtl/station_stop_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// station_stop_sequencer_pkg
//   Shared definitions for the car command path: drive command encodings,
//   FSM state codes and a helper that folds unused command codes onto STOP.
//   The command codes and state codes are shared with the motor drive block
//   and its bench, so their values must not change.
// ----------------------------------------------------------------------------
package station_stop_sequencer_pkg;

    localparam logic [2:0] CMD_STOP  = 3'b000;
    localparam logic [2:0] CMD_FWD   = 3'b001;
    localparam logic [2:0] CMD_REV   = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b011;
    localparam logic [2:0] CMD_RIGHT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    // Codes 101..111 have no meaning to the motor block; treat them as STOP.
    function automatic logic [2:0] norm_cmd(input logic [2:0] cmd);
        return (cmd > CMD_RIGHT) ? CMD_STOP : cmd;
    endfunction

    // Straight-line commands are the only ones that stop at a station.
    function automatic logic is_straight(input logic [2:0] cmd);
        return (cmd == CMD_FWD) || (cmd == CMD_REV);
    endfunction

endpackage

// File: rtl/station_stop_sequencer_if.sv
// ----------------------------------------------------------------------------
// station_stop_sequencer_if
//   Bundles the operator/reed inputs and the drive/status outputs of the
//   station stop sequencer.
//   Signals:
//     user_cmd       raw operator switches (CMD_* encoding, asynchronous)
//     reed_raw       raw reed switch, 1 = magnet present (asynchronous)
//     drive_cmd      registered command to the motor block
//     dwelling       1 while stopped at a station
//     station_count  number of stations stopped at, wraps
//   Modports:
//     master  upstream side: drives the raw inputs, observes the outputs
//     slave   sequencer side
// ----------------------------------------------------------------------------
interface station_stop_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic [2:0]       user_cmd;
    logic             reed_raw;
    logic [2:0]       drive_cmd;
    logic             dwelling;
    logic [CNT_W-1:0] station_count;

    modport master (
        output user_cmd,
        output reed_raw,
        input  drive_cmd,
        input  dwelling,
        input  station_count
    );

    modport slave (
        input  user_cmd,
        input  reed_raw,
        output drive_cmd,
        output dwelling,
        output station_count
    );
endinterface

// File: rtl/station_stop_sequencer_sync_debounce.sv
// ----------------------------------------------------------------------------
// sync_debounce
//   Synchronises an asynchronous, bouncy 1-bit input and debounces it.
//   The stable level only flips after the synchronised input has differed
//   from it for DEBOUNCE_CYCLES consecutive cycles. A registered one-cycle
//   pulse marks each 0->1 transition of the stable level.
//   Ports:
//     clk         system clock
//     rst_n       asynchronous active-low reset
//     din         raw asynchronous input
//     level       debounced stable level
//     rise_pulse  one-cycle pulse, one cycle after level rises
// ----------------------------------------------------------------------------
module sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned DB_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   stable_q;
    logic                   stable_d;
    logic                   rise_q;

    wire synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            db_cnt   <= '0;
            stable_q <= 1'b0;
            stable_d <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end

            if (synced == stable_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= synced;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            // Edge detect on the already-registered stable level, so the pulse
            // appears one cycle after the level flips.
            stable_d <= stable_q;
            rise_q   <= stable_q & ~stable_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/station_stop_sequencer.sv
// ----------------------------------------------------------------------------
// station_stop_sequencer
//   Upstream command stage for the motor drive block. Synchronises the
//   operator command, debounces the reed switch, and stops the car for a
//   fixed dwell when a station magnet is seen while driving straight.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of station_stop_sequencer_if
//            (user_cmd, reed_raw in; drive_cmd, dwelling, station_count out)
// ----------------------------------------------------------------------------
module station_stop_sequencer
    import station_stop_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DWELL_CYCLES    = 200_000_000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    station_stop_sequencer_if.slave   bus
);

    logic [SYNC_STAGES-1:0][2:0] cmd_sync;
    logic [2:0]                  cmd;
    logic                        reed_level;
    logic                        reed_event;

    state_t           state;
    logic [2:0]       drive_q;
    logic             dwelling_q;
    logic [31:0]      dwell_cnt;
    logic [CNT_W-1:0] count_q;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_reed (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (bus.reed_raw),
        .level      (reed_level),
        .rise_pulse (reed_event)
    );

    // Operator switches are synchronised but deliberately not debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sync <= '0;
        end else begin
            cmd_sync[0] <= bus.user_cmd;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                cmd_sync[i] <= cmd_sync[i-1];
            end
        end
    end

    assign cmd = norm_cmd(cmd_sync[SYNC_STAGES-1]);

    // Outputs are registered alongside the state; each branch sets the values
    // that belong to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drive_q    <= CMD_STOP;
            dwelling_q <= 1'b0;
            dwell_cnt  <= '0;
            count_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    dwelling_q <= 1'b0;
                    drive_q    <= cmd;
                    if (cmd != CMD_STOP) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Operator STOP wins over a coincident station event.
                    if (cmd == CMD_STOP) begin
                        state   <= ST_IDLE;
                        drive_q <= CMD_STOP;
                    end else if (reed_event && is_straight(cmd)) begin
                        state      <= ST_DWELL;
                        drive_q    <= CMD_STOP;
                        dwelling_q <= 1'b1;
                        dwell_cnt  <= '0;
                        count_q    <= count_q + CNT_W'(1);
                    end else begin
                        drive_q <= cmd;
                    end
                end

                ST_DWELL: begin
                    if (cmd == CMD_STOP) begin
                        state      <= ST_IDLE;
                        drive_q    <= CMD_STOP;
                        dwelling_q <= 1'b0;
                    end else if (dwell_cnt == 32'(DWELL_CYCLES - 1)) begin
                        state      <= ST_RUN;
                        drive_q    <= cmd;
                        dwelling_q <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 32'd1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    drive_q    <= CMD_STOP;
                    dwelling_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.drive_cmd     = drive_q;
    assign bus.dwelling      = dwelling_q;
    assign bus.station_count = count_q;

endmodule

// File: tb/tb_station_stop_sequencer.sv
module tb_station_stop_sequencer;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 8;
    localparam int unsigned DWELL = 20;
    localparam int unsigned CW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    station_stop_sequencer_if #(.CNT_W(CW)) bus ();

    station_stop_sequencer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.user_cmd = 3'b000;
        bus.reed_raw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.drive_cmd !== 3'b000) begin
            errors++; $display("FAIL reset_drive: got %b want 000", bus.drive_cmd);
        end
        checks++;
        if (bus.dwelling !== 1'b0) begin
            errors++; $display("FAIL reset_dwelling: got %b want 0", bus.dwelling);
        end
        checks++;
        if (bus.station_count !== 8'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", bus.station_count);
        end
    endtask

    task automatic test_fwd_latency();
        do_reset();
        bus.user_cmd = 3'b001;
        tick(2);
        checks++;
        if (bus.drive_cmd !== 3'b000) begin
            errors++; $display("FAIL fwd_early: got %b want 000", bus.drive_cmd);
        end
        tick(1);
        checks++;
        if (bus.drive_cmd !== 3'b001) begin
            errors++; $display("FAIL fwd_latency: got %b want 001", bus.drive_cmd);
        end
        checks++;
        if (bus.dwelling !== 1'b0 || bus.station_count !== 8'd0) begin
            errors++; $display("FAIL fwd_status: got dw=%b cnt=%0d want dw=0 cnt=0",
                               bus.dwelling, bus.station_count);
        end
    endtask

    task automatic test_station_stop();
        do_reset();
        bus.user_cmd = 3'b001;
        tick(3);
        // two 3-cycle bounces before the magnet settles
        repeat (2) begin
            bus.reed_raw = 1'b1; tick(3);
            bus.reed_raw = 1'b0; tick(3);
        end
        bus.reed_raw = 1'b1;
        tick(11);
        checks++;
        if (bus.drive_cmd !== 3'b001) begin
            errors++; $display("FAIL stop_early: got %b want 001", bus.drive_cmd);
        end
        tick(1);
        checks++;
        if (bus.drive_cmd !== 3'b000 || bus.dwelling !== 1'b1 || bus.station_count !== 8'd1) begin
            errors++; $display("FAIL stop_enter: got drv=%b dw=%b cnt=%0d want 000/1/1",
                               bus.drive_cmd, bus.dwelling, bus.station_count);
        end
        for (int k = 13; k <= 31; k++) begin
            if (k == 30) bus.reed_raw = 1'b0;
            tick(1);
            checks++;
            if (bus.drive_cmd !== 3'b000 || bus.dwelling !== 1'b1) begin
                errors++; $display("FAIL stop_dwell k=%0d: got drv=%b dw=%b want 000/1",
                                   k, bus.drive_cmd, bus.dwelling);
            end
        end
        tick(1);
        checks++;
        if (bus.drive_cmd !== 3'b001 || bus.dwelling !== 1'b0 || bus.station_count !== 8'd1) begin
            errors++; $display("FAIL stop_resume: got drv=%b dw=%b cnt=%0d want 001/0/1",
                               bus.drive_cmd, bus.dwelling, bus.station_count);
        end
        tick(20);
        checks++;
        if (bus.drive_cmd !== 3'b001 || bus.station_count !== 8'd1) begin
            errors++; $display("FAIL stop_no_retrigger: got drv=%b cnt=%0d want 001/1",
                               bus.drive_cmd, bus.station_count);
        end
    endtask

    task automatic test_short_pulses();
        do_reset();
        bus.user_cmd = 3'b001;
        tick(3);
        repeat (4) begin
            bus.reed_raw = 1'b1; tick(7);
            bus.reed_raw = 1'b0; tick(7);
        end
        tick(15);
        checks++;
        if (bus.drive_cmd !== 3'b001 || bus.station_count !== 8'd0 || bus.dwelling !== 1'b0) begin
            errors++; $display("FAIL short_pulses: got drv=%b cnt=%0d dw=%b want 001/0/0",
                               bus.drive_cmd, bus.station_count, bus.dwelling);
        end
    endtask

    task automatic test_dwell_abort();
        do_reset();
        bus.user_cmd = 3'b001;
        tick(3);
        bus.reed_raw = 1'b1;
        tick(12);
        checks++;
        if (bus.dwelling !== 1'b1 || bus.station_count !== 8'd1) begin
            errors++; $display("FAIL abort_enter: got dw=%b cnt=%0d want 1/1",
                               bus.dwelling, bus.station_count);
        end
        tick(3);
        bus.user_cmd = 3'b000;
        tick(2);
        checks++;
        if (bus.dwelling !== 1'b1) begin
            errors++; $display("FAIL abort_early: got dw=%b want 1", bus.dwelling);
        end
        tick(1);
        checks++;
        if (bus.dwelling !== 1'b0 || bus.drive_cmd !== 3'b000 || bus.station_count !== 8'd1) begin
            errors++; $display("FAIL abort_idle: got dw=%b drv=%b cnt=%0d want 0/000/1",
                               bus.dwelling, bus.drive_cmd, bus.station_count);
        end
        bus.user_cmd = 3'b010;
        tick(3);
        checks++;
        if (bus.drive_cmd !== 3'b010 || bus.station_count !== 8'd1 || bus.dwelling !== 1'b0) begin
            errors++; $display("FAIL abort_rev: got drv=%b cnt=%0d dw=%b want 010/1/0",
                               bus.drive_cmd, bus.station_count, bus.dwelling);
        end
        bus.reed_raw = 1'b0;
        tick(15);
    endtask

    task automatic test_turn_and_priority();
        do_reset();
        bus.user_cmd = 3'b011;
        tick(3);
        bus.reed_raw = 1'b1;
        tick(14);
        checks++;
        if (bus.drive_cmd !== 3'b011 || bus.station_count !== 8'd0 || bus.dwelling !== 1'b0) begin
            errors++; $display("FAIL turn_ignore: got drv=%b cnt=%0d dw=%b want 011/0/0",
                               bus.drive_cmd, bus.station_count, bus.dwelling);
        end
        bus.reed_raw = 1'b0;
        tick(15);
        bus.user_cmd = 3'b001;
        tick(3);
        // STOP reaches the FSM on the same edge the station event does
        bus.reed_raw = 1'b1;
        tick(9);
        bus.user_cmd = 3'b000;
        tick(2);
        checks++;
        if (bus.drive_cmd !== 3'b001) begin
            errors++; $display("FAIL prio_before: got %b want 001", bus.drive_cmd);
        end
        tick(1);
        checks++;
        if (bus.drive_cmd !== 3'b000 || bus.dwelling !== 1'b0 || bus.station_count !== 8'd0) begin
            errors++; $display("FAIL prio_stop: got drv=%b dw=%b cnt=%0d want 000/0/0",
                               bus.drive_cmd, bus.dwelling, bus.station_count);
        end
        // the discarded event must not be replayed on resume
        bus.user_cmd = 3'b001;
        tick(6);
        checks++;
        if (bus.drive_cmd !== 3'b001 || bus.dwelling !== 1'b0 || bus.station_count !== 8'd0) begin
            errors++; $display("FAIL prio_no_queue: got drv=%b dw=%b cnt=%0d want 001/0/0",
                               bus.drive_cmd, bus.dwelling, bus.station_count);
        end
        bus.reed_raw = 1'b0;
        tick(15);
    endtask

    task automatic test_invalid_cmd();
        do_reset();
        bus.user_cmd = 3'b110;
        tick(5);
        checks++;
        if (bus.drive_cmd !== 3'b000) begin
            errors++; $display("FAIL invalid_110: got %b want 000", bus.drive_cmd);
        end
        bus.user_cmd = 3'b100;
        tick(3);
        checks++;
        if (bus.drive_cmd !== 3'b100) begin
            errors++; $display("FAIL right_cmd: got %b want 100", bus.drive_cmd);
        end
        bus.user_cmd = 3'b111;
        tick(3);
        checks++;
        if (bus.drive_cmd !== 3'b000) begin
            errors++; $display("FAIL invalid_111: got %b want 000", bus.drive_cmd);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] expc;
        do_reset();
        bus.user_cmd = 3'b001;
        tick(3);
        for (int i = 0; i < 256; i++) begin
            expc = 8'(i + 1);
            bus.reed_raw = 1'b1;
            tick(12);
            checks++;
            if (bus.dwelling !== 1'b1 || bus.station_count !== expc) begin
                errors++; $display("FAIL wrap_pass %0d: got dw=%b cnt=%0d want 1/%0d",
                                   i, bus.dwelling, bus.station_count, expc);
            end
            bus.reed_raw = 1'b0;
            tick(22);
        end
        checks++;
        if (bus.station_count !== 8'd0 || bus.drive_cmd !== 3'b001) begin
            errors++; $display("FAIL wrap_final: got cnt=%0d drv=%b want 0/001",
                               bus.station_count, bus.drive_cmd);
        end
        bus.reed_raw = 1'b1;
        tick(17);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.drive_cmd !== 3'b000 || bus.station_count !== 8'd0 || bus.dwelling !== 1'b0) begin
            errors++; $display("FAIL reset_mid_dwell: got drv=%b cnt=%0d dw=%b want 000/0/0",
                               bus.drive_cmd, bus.station_count, bus.dwelling);
        end
        bus.reed_raw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        bus.user_cmd = 3'b000;
        bus.reed_raw = 1'b0;
        test_reset();
        test_fwd_latency();
        test_station_stop();
        test_short_pulses();
        test_dwell_abort();
        test_turn_and_priority();
        test_invalid_cmd();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
